// File: rtl/character_move_sequencer.sv
// Per-frame movement sequencer. On each frame tick it snapshots the four
// characters' direction requests, proposes a clamped candidate position for
// each character in fixed order 0..3, asks the collision detector and either
// commits or rejects each move. Committed positions are authoritative.
module character_move_sequencer #(
  parameter int unsigned STEP     = 2,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned CHAR_W   = 32,
  parameter int unsigned CHAR_H   = 32,
  parameter int unsigned INIT_X0  = 40,
  parameter int unsigned INIT_X1  = 200,
  parameter int unsigned INIT_X2  = 360,
  parameter int unsigned INIT_X3  = 520,
  parameter int unsigned INIT_Y0  = 400,
  parameter int unsigned INIT_Y1  = 400,
  parameter int unsigned INIT_Y2  = 400,
  parameter int unsigned INIT_Y3  = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [15:0] dir_req,
  input  logic        move_allowed,
  output logic [9:0]  x0,
  output logic [9:0]  x1,
  output logic [9:0]  x2,
  output logic [9:0]  x3,
  output logic [9:0]  y0,
  output logic [9:0]  y1,
  output logic [9:0]  y2,
  output logic [9:0]  y3,
  output logic [9:0]  test_x,
  output logic [9:0]  test_y,
  output logic [1:0]  character_to_move,
  output logic        busy,
  output logic [3:0]  blocked,
  output logic        sweep_done,
  output logic        frame_overrun
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, EVAL, DONE} state_t;

  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - CHAR_W);
  localparam logic [10:0] Y_MAX  = 11'(SCREEN_H - CHAR_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  INIT_X [4] = '{10'(INIT_X0), 10'(INIT_X1), 10'(INIT_X2), 10'(INIT_X3)};
  localparam logic [9:0]  INIT_Y [4] = '{10'(INIT_Y0), 10'(INIT_Y1), 10'(INIT_Y2), 10'(INIT_Y3)};

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_snap;
  logic [1:0]  r_idx;
  logic [9:0]  r_x [4];
  logic [9:0]  r_y [4];
  logic [9:0]  r_test_x;
  logic [9:0]  r_test_y;
  logic [1:0]  r_ctm;
  logic        r_busy;
  logic [3:0]  r_blocked;
  logic        r_sweep_done;
  logic        r_overrun;

  logic [3:0]  w_req;
  logic [10:0] w_x_cur;
  logic [10:0] w_y_cur;
  logic [10:0] w_x_inc;
  logic [10:0] w_x_dec;
  logic [10:0] w_y_inc;
  logic [10:0] w_y_dec;
  logic [9:0]  w_cand_x;
  logic [9:0]  w_cand_y;
  logic        w_moves;
  logic        w_last;

  // Candidate position for the character at r_idx; opposing requests cancel,
  // 11-bit intermediates catch underflow (bit 10) and overflow before clamping.
  always_comb begin
    w_req    = r_snap[{r_idx, 2'b00} +: 4];
    w_x_cur  = {1'b0, r_x[r_idx]};
    w_y_cur  = {1'b0, r_y[r_idx]};
    w_x_inc  = w_x_cur + STEP_W;
    w_x_dec  = w_x_cur - STEP_W;
    w_y_inc  = w_y_cur + STEP_W;
    w_y_dec  = w_y_cur - STEP_W;
    w_cand_x = r_x[r_idx];
    w_cand_y = r_y[r_idx];
    if (w_req[0] && !w_req[1]) begin
      w_cand_x = (w_x_inc > X_MAX) ? X_MAX[9:0] : w_x_inc[9:0];
    end else if (w_req[1] && !w_req[0]) begin
      w_cand_x = w_x_dec[10] ? '0 : w_x_dec[9:0];
    end
    if (w_req[2] && !w_req[3]) begin
      w_cand_y = (w_y_inc > Y_MAX) ? Y_MAX[9:0] : w_y_inc[9:0];
    end else if (w_req[3] && !w_req[2]) begin
      w_cand_y = w_y_dec[10] ? '0 : w_y_dec[9:0];
    end
    w_moves = (w_cand_x != r_x[r_idx]) || (w_cand_y != r_y[r_idx]);
    w_last  = (r_idx == 2'd3);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; stationary characters skip the detector query.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (frame_tick) w_state_next = LOAD;
      LOAD:    begin
        if (w_moves)     w_state_next = SETTLE;
        else if (w_last) w_state_next = DONE;
        else             w_state_next = LOAD;
      end
      SETTLE:  w_state_next = EVAL;
      EVAL:    w_state_next = w_last ? DONE : LOAD;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Sweep datapath: snapshot, detector query registers, commits and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap       <= '0;
      r_idx        <= '0;
      r_test_x     <= '0;
      r_test_y     <= '0;
      r_ctm        <= '0;
      r_busy       <= 1'b0;
      r_blocked    <= '0;
      r_sweep_done <= 1'b0;
      r_overrun    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_x[i] <= INIT_X[i];
        r_y[i] <= INIT_Y[i];
      end
    end else begin
      r_busy       <= (w_state_next != IDLE);
      r_sweep_done <= (w_state_next == DONE);
      r_overrun    <= frame_tick && (r_state != IDLE);
      unique case (r_state)
        IDLE: begin
          if (frame_tick) begin
            r_snap <= dir_req;
            r_idx  <= '0;
          end
        end
        LOAD: begin
          if (w_moves) begin
            r_test_x <= w_cand_x;
            r_test_y <= w_cand_y;
            r_ctm    <= r_idx;
          end else begin
            r_blocked[r_idx] <= 1'b0;
            if (!w_last) r_idx <= r_idx + 2'd1;
          end
        end
        EVAL: begin
          if (move_allowed) begin
            r_x[r_idx]       <= r_test_x;
            r_y[r_idx]       <= r_test_y;
            r_blocked[r_idx] <= 1'b0;
          end else begin
            r_blocked[r_idx] <= 1'b1;
          end
          if (!w_last) r_idx <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign x0                = r_x[0];
  assign x1                = r_x[1];
  assign x2                = r_x[2];
  assign x3                = r_x[3];
  assign y0                = r_y[0];
  assign y1                = r_y[1];
  assign y2                = r_y[2];
  assign y3                = r_y[3];
  assign test_x            = r_test_x;
  assign test_y            = r_test_y;
  assign character_to_move = r_ctm;
  assign busy              = r_busy;
  assign blocked           = r_blocked;
  assign sweep_done        = r_sweep_done;
  assign frame_overrun     = r_overrun;

endmodule

// File: tb/tb_character_move_sequencer.sv
// Bench for character_move_sequencer: a reference model predicts every cycle
// of each sweep into a scoreboard queue; a negedge monitor pops and compares.
module tb_character_move_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [15:0] dir_req;
  logic        move_allowed;
  logic [9:0]  x0, x1, x2, x3, y0, y1, y2, y3;
  logic [9:0]  test_x, test_y;
  logic [1:0]  character_to_move;
  logic        busy;
  logic [3:0]  blocked;
  logic        sweep_done;
  logic        frame_overrun;

  int n_assert = 0;
  int n_fail   = 0;

  character_move_sequencer dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir_req(dir_req),
    .move_allowed(move_allowed),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .test_x(test_x), .test_y(test_y), .character_to_move(character_to_move),
    .busy(busy), .blocked(blocked), .sweep_done(sweep_done),
    .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  int   mx [4];
  int   my [4];
  logic [3:0] mblk;
  int   last_tx, last_ty, last_ctm;

  typedef struct {
    int tx; int ty; int ctm; bit bsy; bit done; bit ovr;
  } exp_t;
  exp_t sb [$];
  exp_t mon_e;
  bit   mon_active = 1'b0;

  // Detector environment: forced verdict or a real rectangle-overlap check
  bit use_det     = 1'b0;
  bit force_allow = 1'b1;
  int px [4];
  int py [4];

  function automatic bit free_at(input int idx, input int tx, input int ty,
                                 input int ox [4], input int oy [4]);
    for (int j = 0; j < 4; j++) begin
      if (j != idx && tx < ox[j] + 32 && ox[j] < tx + 32 &&
          ty < oy[j] + 32 && oy[j] < ty + 32) return 1'b0;
    end
    return 1'b1;
  endfunction

  always_comb begin
    px[0] = int'(x0); px[1] = int'(x1); px[2] = int'(x2); px[3] = int'(x3);
    py[0] = int'(y0); py[1] = int'(y1); py[2] = int'(y2); py[3] = int'(y3);
  end

  always_comb begin
    if (use_det) move_allowed = free_at(int'(character_to_move), int'(test_x), int'(test_y), px, py);
    else         move_allowed = force_allow;
  end

  task automatic model_reset();
    mx = '{40, 200, 360, 520};
    my = '{400, 400, 400, 400};
    mblk = '0;
    last_tx = 0; last_ty = 0; last_ctm = 0;
  endtask

  function automatic exp_t mk(input bit bsy, input bit done);
    exp_t e;
    e.tx = last_tx; e.ty = last_ty; e.ctm = last_ctm;
    e.bsy = bsy; e.done = done; e.ovr = 1'b0;
    return e;
  endfunction

  // Predict every cycle of a sweep (LOAD of idx 0 is cycle 0) plus one idle cycle.
  task automatic predict_sweep(input logic [15:0] dir, input int ovr_at);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] r;
      int cx, cy;
      bit ok;
      r  = dir[4*i +: 4];
      cx = mx[i]; cy = my[i];
      if (r[0] && !r[1]) cx = (mx[i] + 2 > 608) ? 608 : mx[i] + 2;
      if (r[1] && !r[0]) cx = (mx[i] - 2 < 0) ? 0 : mx[i] - 2;
      if (r[2] && !r[3]) cy = (my[i] + 2 > 448) ? 448 : my[i] + 2;
      if (r[3] && !r[2]) cy = (my[i] - 2 < 0) ? 0 : my[i] - 2;
      sb.push_back(mk(1'b1, 1'b0));
      if (cx != mx[i] || cy != my[i]) begin
        last_tx = cx; last_ty = cy; last_ctm = i;
        sb.push_back(mk(1'b1, 1'b0));
        sb.push_back(mk(1'b1, 1'b0));
        ok = use_det ? free_at(i, cx, cy, mx, my) : force_allow;
        if (ok) begin mx[i] = cx; my[i] = cy; mblk[i] = 1'b0; end
        else    mblk[i] = 1'b1;
      end else begin
        mblk[i] = 1'b0;
      end
    end
    sb.push_back(mk(1'b1, 1'b1));
    sb.push_back(mk(1'b0, 1'b0));
    if (ovr_at >= 0) sb[ovr_at + 1].ovr = 1'b1;
  endtask

  // Start a sweep and drive an optional extra tick in cycle ovr_at.
  task automatic run_sweep(input logic [15:0] dir, input int ovr_at);
    int n_cyc;
    predict_sweep(dir, ovr_at);
    n_cyc = sb.size();
    @(negedge clk);
    dir_req = dir; frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    dir_req = 16'($urandom);
    mon_active = 1'b1;
    for (int n = 0; n < n_cyc; n++) begin
      @(negedge clk);
      frame_tick = (n == ovr_at);
    end
    frame_tick = 1'b0;
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_active && sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_assert++;
      if (test_x !== 10'(mon_e.tx)) begin n_fail++; $display("FAIL sb_test_x got %0d exp %0d", test_x, mon_e.tx); end
      n_assert++;
      if (test_y !== 10'(mon_e.ty)) begin n_fail++; $display("FAIL sb_test_y got %0d exp %0d", test_y, mon_e.ty); end
      n_assert++;
      if (character_to_move !== 2'(mon_e.ctm)) begin n_fail++; $display("FAIL sb_ctm got %0d exp %0d", character_to_move, mon_e.ctm); end
      n_assert++;
      if (busy !== mon_e.bsy) begin n_fail++; $display("FAIL sb_busy got %b exp %b", busy, mon_e.bsy); end
      n_assert++;
      if (sweep_done !== mon_e.done) begin n_fail++; $display("FAIL sb_sweep_done got %b exp %b", sweep_done, mon_e.done); end
      n_assert++;
      if (frame_overrun !== mon_e.ovr) begin n_fail++; $display("FAIL sb_overrun got %b exp %b", frame_overrun, mon_e.ovr); end
      if (sb.size() == 0) mon_active = 1'b0;
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; frame_tick = 1'b0; dir_req = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_assert++; if (x0 !== 10'd40)  begin n_fail++; $display("FAIL reset_x0 got %0d exp 40", x0); end
    n_assert++; if (y0 !== 10'd400) begin n_fail++; $display("FAIL reset_y0 got %0d exp 400", y0); end
    n_assert++; if (x3 !== 10'd520) begin n_fail++; $display("FAIL reset_x3 got %0d exp 520", x3); end
    n_assert++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_assert++; if (blocked !== 4'b0) begin n_fail++; $display("FAIL reset_blocked got %b exp 0000", blocked); end
    n_assert++; if (test_x !== 10'd0 || character_to_move !== 2'd0) begin
      n_fail++; $display("FAIL reset_test got %0d/%0d exp 0/0", test_x, character_to_move); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_move();
    use_det = 1'b0; force_allow = 1'b1;
    run_sweep(16'h0001, -1);
    n_assert++; if (x0 !== 10'd42) begin n_fail++; $display("FAIL free_x0 got %0d exp 42", x0); end
    n_assert++; if (blocked !== 4'b0) begin n_fail++; $display("FAIL free_blocked got %b exp 0000", blocked); end
  endtask

  task automatic test_blocked();
    use_det = 1'b0; force_allow = 1'b0;
    run_sweep(16'h0080, -1);
    n_assert++; if (y1 !== 10'd400) begin n_fail++; $display("FAIL blk_y1 got %0d exp 400", y1); end
    n_assert++; if (blocked !== 4'b0010) begin n_fail++; $display("FAIL blk_flags got %b exp 0010", blocked); end
    force_allow = 1'b1;
    run_sweep(16'h0080, -1);
    n_assert++; if (y1 !== 10'd398) begin n_fail++; $display("FAIL blk_retry_y1 got %0d exp 398", y1); end
    n_assert++; if (blocked !== 4'b0000) begin n_fail++; $display("FAIL blk_retry_flags got %b exp 0000", blocked); end
  endtask

  task automatic test_clamp();
    use_det = 1'b1;
    for (int k = 0; k < 45; k++) run_sweep(16'h1402, -1);
    n_assert++; if (x0 !== 10'd0)   begin n_fail++; $display("FAIL clamp_x0 got %0d exp 0", x0); end
    n_assert++; if (y2 !== 10'd448) begin n_fail++; $display("FAIL clamp_y2 got %0d exp 448", y2); end
    n_assert++; if (x3 !== 10'd608) begin n_fail++; $display("FAIL clamp_x3 got %0d exp 608", x3); end
    run_sweep(16'h00C3, -1);
    n_assert++; if (x0 !== 10'd0 || y1 !== 10'd398) begin
      n_fail++; $display("FAIL cancel_pos got %0d/%0d exp 0/398", x0, y1); end
    n_assert++; if (blocked !== 4'b0) begin n_fail++; $display("FAIL cancel_blocked got %b exp 0000", blocked); end
  endtask

  task automatic test_overrun();
    use_det = 1'b1;
    run_sweep(16'h0800, 2);
    n_assert++; if (y2 !== 10'd446) begin n_fail++; $display("FAIL ovr_y2 got %0d exp 446", y2); end
    repeat (3) begin
      @(negedge clk);
      n_assert++; if (sweep_done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL ovr_idle got done=%b busy=%b exp 0/0", sweep_done, busy); end
    end
  endtask

  task automatic test_sequential();
    @(negedge clk); rst_n = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    use_det = 1'b1;
    for (int k = 0; k < 63; k++) run_sweep(16'h0001, -1);
    n_assert++; if (x0 !== 10'd166) begin n_fail++; $display("FAIL seq_pre_x0 got %0d exp 166", x0); end
    run_sweep(16'h0021, -1);
    n_assert++; if (x0 !== 10'd168) begin n_fail++; $display("FAIL seq_x0 got %0d exp 168", x0); end
    n_assert++; if (x1 !== 10'd200) begin n_fail++; $display("FAIL seq_x1 got %0d exp 200", x1); end
    n_assert++; if (blocked !== 4'b0010) begin n_fail++; $display("FAIL seq_blocked got %b exp 0010", blocked); end
  endtask

  task automatic test_reset_mid_sweep();
    use_det = 1'b0; force_allow = 1'b1;
    @(negedge clk);
    dir_req = 16'h0081; frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_assert++; if (x0 !== 10'd40 || y1 !== 10'd400) begin
      n_fail++; $display("FAIL midrst_pos got %0d/%0d exp 40/400", x0, y1); end
    n_assert++; if (busy !== 1'b0 || blocked !== 4'b0) begin
      n_fail++; $display("FAIL midrst_flags got busy=%b blk=%b exp 0/0000", busy, blocked); end
    n_assert++; if (test_x !== 10'd0) begin n_fail++; $display("FAIL midrst_test_x got %0d exp 0", test_x); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    run_sweep(16'h0001, -1);
    n_assert++; if (x0 !== 10'd42) begin n_fail++; $display("FAIL midrst_recover_x0 got %0d exp 42", x0); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_move();
    test_blocked();
    test_clamp();
    test_overrun();
    test_sequential();
    test_reset_mid_sweep();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/character_move_sequencer.md
Name: character_move_sequencer

Overview:
- Per-frame movement sequencer that sits directly upstream of the character collision detector.
- On each frame tick it snapshots the direction requests for mage, gunman, swordman and fistman (index 0 to 3).
- For each character in turn it proposes a clamped candidate position on test_x/test_y/character_to_move, samples move_allowed, and commits or rejects the move.
- Its committed positions are the authoritative character positions fed back to the detector and the renderer.

Parameters:
- STEP, 2, pixels moved per axis per frame.
- SCREEN_W, 640, playfield width in pixels.
- SCREEN_H, 480, playfield height in pixels.
- CHAR_W, 32, character width; also drives the detector width input.
- CHAR_H, 32, character height; also drives the detector height input.
- INIT_X0..INIT_X3, 40/200/360/520, reset x per character.
- INIT_Y0..INIT_Y3, 400 each, reset y per character.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse, start of movement sweep
- dir_req  in  16  per character {up,down,left,right}; character i at bits [4i+3:4i]
- move_allowed  in  1  detector verdict for the current test position
- x0..x3  out  10 each  committed x position (mage, gunman, swordman, fistman)
- y0..y3  out  10 each  committed y position
- test_x  out  10  candidate x presented to detector
- test_y  out  10  candidate y presented to detector
- character_to_move  out  2  index of character under test
- busy  out  1  high while a sweep is in progress
- blocked  out  4  per character: last proposed move rejected
- sweep_done  out  1  one-cycle pulse when the sweep completes
- frame_overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is asynchronous and active-low.
  - Positions reset to the INIT_* values.
  - test_x, test_y and character_to_move reset to 0; state resets to IDLE.
  - busy, blocked, sweep_done and frame_overrun reset to 0.
  - Reset asserted mid-sweep aborts the sweep; no partial commit survives.
- FSM states: IDLE, LOAD, SETTLE, EVAL, DONE.
- IDLE: on frame_tick, register dir_req into a snapshot, set idx=0, set busy=1, go to LOAD. Later changes to dir_req do not affect the sweep.
- LOAD: compute the candidate for idx from the snapshot.
  - up and down both set gives dy=0; left and right both set gives dx=0.
  - x decrement saturates at 0; x increment clamps at SCREEN_W-CHAR_W.
  - y decrement saturates at 0; y increment clamps at SCREEN_H-CHAR_H.
  - If the candidate equals the current position (no request, or cancelled/clamped to no change): clear blocked[idx] and advance without querying the detector.
  - Otherwise register test_x, test_y and character_to_move=idx, then go to SETTLE.
- SETTLE: hold the test outputs for one cycle so the combinational detector path can settle. Go to EVAL.
- EVAL: sample move_allowed.
  - If 1: commit the candidate to x[idx]/y[idx] and clear blocked[idx].
  - If 0: leave the position unchanged and set blocked[idx].
  - Then advance.
- Advance: if idx==3 go to DONE; otherwise idx+1 and go to LOAD.
- DONE: pulse sweep_done for one cycle, drop busy, return to IDLE.
- Sequential commit: a character committed earlier in a sweep is visible to the detector checks of later characters in the same sweep. Order is fixed: 0 to 3.
- Latency: a moving character costs 3 cycles and a stationary one costs 1. A sweep takes at most 13 cycles including DONE.
- test_x, test_y and character_to_move hold their last values outside SETTLE/EVAL.
- Arithmetic: use 11-bit intermediates for add and subtract to detect underflow and overflow before clamping. Outputs are 10 bits.
- frame_tick while busy: ignored (no restart, no queuing) and frame_overrun pulses for one cycle.
- frame_tick in the same cycle as the DONE state: also counts as overrun. A new sweep starts only from IDLE.

Test Plan:
- Reset values: assert rst_n=0 mid-simulation → x0=40, y0=400, x3=520, busy=0, blocked=0, state IDLE within the same cycle (asynchronous).
- Free move: dir_req[3:0]=0001 (right), move_allowed=1, frame_tick → character_to_move=0, test_x=42 in SETTLE; x0=42 after EVAL; sweep_done 6 cycles after tick (3+1+1+1 cycles, plus DONE).
- Blocked move: dir_req for gunman=1000 (up), move_allowed=0 in EVAL → y1 stays 400, blocked=0010; next sweep with the move allowed → y1=398, blocked[1]=0.
- Clamp and cancel:
  - x0=0 with left pressed → candidate equals current, no detector query (character_to_move never shows 0 in SETTLE), blocked[0]=0.
  - left+right both pressed → same: no query.
  - x at 607 moving right → test_x=608 (SCREEN_W-CHAR_W=608).
- Sequential visibility: mage moves right from 40 to 42; the gunman's check in the same sweep sees x0=42 on the detector bus. Drive move_allowed from the actual collision detector and confirm the verdict uses the updated mage position.
- Overrun and reset mid-sweep:
  - Second frame_tick during LOAD of idx 2 → frame_overrun single pulse, sweep completes normally with a single sweep_done.
  - rst_n low during EVAL of idx 1 → positions return to INIT values, no commit.
